// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the colour-sensor frequency counter.
package freq_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    DONE
  } state_t;

  localparam int GATE_CYCLES_1MS   = 100000;
  localparam int SETTLE_CYCLES_DEF = 1000;

  // Phase timer must hold the larger of the two reload values.
  function automatic int timer_width(input int gate_cycles, input int settle_cycles);
    int m;
    m = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/freq_counter_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, prev;

  // NOTE: non-blocking assignments make each flop take its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      prev  <= s2;
      pulse <= s2 & ~prev;
    end
  end

endmodule

// File: rtl/freq_counter.sv
// Gated edge counter: settle, count sensor edges for GATE_CYCLES, report once.
module freq_counter
  import freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES   = GATE_CYCLES_1MS,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_freq,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int               TW          = timer_width(GATE_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0]    GATE_LOAD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] work, work_nxt;
  logic             work_ovf, ovf_nxt;
  logic             edge_pulse;

  edge_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sensor_freq),
    .pulse (edge_pulse)
  );

  // NOTE: every output gets a default first so always_comb never infers a latch.
  always_comb begin
    work_nxt = work;
    ovf_nxt  = work_ovf;
    if (edge_pulse) begin
      if (work == CNT_MAX) ovf_nxt  = 1'b1;
      else                 work_nxt = work + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      work     <= '0;
      work_ovf <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work     <= '0;
            work_ovf <= 1'b0;
            busy     <= 1'b1;
            if (SETTLE_CYCLES == 0) begin
              state <= GATE;
              timer <= GATE_LOAD;
            end else begin
              state <= SETTLE;
              timer <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            state <= GATE;
            timer <= GATE_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GATE: begin
          work     <= work_nxt;
          work_ovf <= ovf_nxt;
          if (timer == '0) begin
            // The last window cycle's edge is folded straight into the result.
            state    <= DONE;
            done     <= 1'b1;
            count    <= work_nxt;
            overflow <= ovf_nxt;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_counter.sv
// Directed bench: three freq_counter configurations checked against a window-arithmetic model.
module tb_freq_counter;

  localparam int G = 100;
  localparam int S_CFG [3] = '{10, 10, 0};
  localparam int W_CFG [3] = '{32, 4, 32};

  typedef struct {
    int     inst;
    int     edge_n;
    bit     dn;
    longint cnt;
    bit     ovf;
  } pin_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_v [3];
  logic sen_v   [3];
  logic busy_v  [3];
  logic done_v  [3];
  logic ovf_v   [3];
  logic [31:0] cnt0, cnt2;
  logic [3:0]  cnt1;

  int  period_v [3];
  int  e = 0;
  int  n_tests = 0;
  int  n_fail  = 0;

  // Model state
  int     k_m      [3];
  bit     sen_prev [3];
  bit     rise_at  [3][1024];
  bit     exp_busy [3];
  bit     exp_done [3];
  bit     exp_ovf  [3];
  longint exp_cnt  [3];
  pin_t   pins [$];

  always #5 clk = ~clk;

  freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(10), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .sensor_freq(sen_v[0]), .start(start_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .count(cnt0), .overflow(ovf_v[0]));

  freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(10), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .sensor_freq(sen_v[1]), .start(start_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .count(cnt1), .overflow(ovf_v[1]));

  freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(0), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .sensor_freq(sen_v[2]), .start(start_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .count(cnt2), .overflow(ovf_v[2]));

  function automatic logic [63:0] pack(input logic b, input logic d, input logic o, input logic [31:0] c);
    return {29'b0, b, d, o, c};
  endfunction

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return {28'b0, cnt1};
      default: return cnt2;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (busy,done,ovf,count)", name, act, exp);
    end
  endtask

  // Model: a measurement started at edge k reports at edge k+S+G the number of
  // sensor rises whose pulse (rise + 3 edges) falls in edges k+S+1 .. k+S+G.
  always @(posedge clk) begin
    e = e + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        k_m[i]      = -100000;
        sen_prev[i] = 1'b0;
        exp_busy[i] = 1'b0;
        exp_done[i] = 1'b0;
        exp_ovf[i]  = 1'b0;
        exp_cnt[i]  = 0;
      end else begin
        if (sen_v[i] && !sen_prev[i] && e < 1024) rise_at[i][e] = 1'b1;
        sen_prev[i] = sen_v[i];
        if (start_v[i] && e >= k_m[i] + S_CFG[i] + G + 2) k_m[i] = e;
        exp_busy[i] = (e >= k_m[i]) && (e <= k_m[i] + S_CFG[i] + G);
        exp_done[i] = (e == k_m[i] + S_CFG[i] + G);
        if (exp_done[i]) begin
          longint n, maxv;
          n    = 0;
          maxv = (longint'(1) << W_CFG[i]) - 1;
          for (int r = k_m[i] + S_CFG[i] + 1 - 3; r <= k_m[i] + S_CFG[i] + G - 3; r++)
            if (r >= 0 && rise_at[i][r]) n++;
          exp_cnt[i] = (n > maxv) ? maxv : n;
          exp_ovf[i] = (n > maxv);
        end
      end
    end
  end

  // Single compare process: full model check every cycle plus pinned literals.
  always @(negedge clk) begin
    if (e > 0) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("inst%0d cycle e=%0d", i, e),
              pack(busy_v[i], done_v[i], ovf_v[i], dut_cnt(i)),
              pack(exp_busy[i], exp_done[i], exp_ovf[i], exp_cnt[i][31:0]));
      foreach (pins[p])
        if (pins[p].edge_n == e)
          check($sformatf("pin inst%0d e=%0d", pins[p].inst, e),
                pack(1'b0, done_v[pins[p].inst], ovf_v[pins[p].inst], dut_cnt(pins[p].inst)),
                pack(1'b0, pins[p].dn, pins[p].ovf, pins[p].cnt[31:0]));
    end
  end

  // Sensor square waves; period 0 holds the line low.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 3; i++)
      sen_v[i] = (period_v[i] > 0) && ((e % period_v[i]) < (period_v[i] / 2));
  end

  task automatic run_to(input int n);
    do @(negedge clk); while (e < n);
    #1;
  endtask

  task automatic pulse_start(input bit [2:0] m, input int k);
    run_to(k - 1);
    for (int i = 0; i < 3; i++) if (m[i]) start_v[i] = 1'b1;
    run_to(k);
    for (int i = 0; i < 3; i++) if (m[i]) start_v[i] = 1'b0;
  endtask

  task automatic add_pin(input int i, input int en, input bit dn, input longint c, input bit o);
    pin_t p;
    p.inst = i; p.edge_n = en; p.dn = dn; p.cnt = c; p.ovf = o;
    pins.push_back(p);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      sen_v[i]   = 1'b0;
      k_m[i]     = -100000;
    end
    period_v = '{10, 4, 10};

    add_pin(0, 119, 0, 0, 0);  add_pin(0, 120, 1, 10, 0); add_pin(0, 121, 0, 10, 0);
    add_pin(0, 232, 0, 10, 0); add_pin(0, 359, 0, 10, 0); add_pin(0, 360, 1, 0, 0);
    add_pin(0, 509, 0, 0, 0);  add_pin(0, 510, 1, 5, 0);  add_pin(0, 660, 0, 0, 0);
    add_pin(0, 710, 0, 0, 0);  add_pin(0, 859, 0, 0, 0);  add_pin(0, 860, 1, 10, 0);
    add_pin(1, 120, 1, 15, 1); add_pin(1, 359, 0, 15, 1); add_pin(1, 360, 1, 5, 0);
    add_pin(2, 109, 0, 0, 0);  add_pin(2, 110, 1, 10, 0); add_pin(2, 300, 1, 10, 0);
    add_pin(2, 301, 0, 10, 0); add_pin(2, 401, 0, 10, 0); add_pin(2, 402, 1, 10, 0);
    add_pin(2, 504, 1, 10, 0); add_pin(2, 505, 0, 10, 0);

    run_to(3);
    rst = 1'b0;

    pulse_start(3'b111, 10);
    pulse_start(3'b001, 15);    // during SETTLE
    pulse_start(3'b001, 60);    // during GATE
    pulse_start(3'b001, 121);   // during DONE

    run_to(130);
    period_v[0] = 0;
    period_v[1] = 20;

    run_to(199);
    start_v[2] = 1'b1;          // held: back-to-back measurements
    pulse_start(3'b011, 250);

    run_to(370);
    period_v[0] = 20;
    pulse_start(3'b001, 400);

    run_to(500);
    start_v[2] = 1'b0;

    run_to(530);
    period_v[0] = 10;
    pulse_start(3'b001, 600);

    run_to(659);
    rst = 1'b1;                 // abort mid-GATE
    run_to(661);
    rst = 1'b0;

    pulse_start(3'b001, 750);
    run_to(900);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
